// File: rtl/hash_uart_tx_pkg.sv
// Shared constants and FSM encoding for the hash UART transmitter.
// Optional build macro: HASH_TX_SYNC_BYTE_EN adds a leading 0xA5 sync frame.
package hash_tx_pkg;

  localparam int HASH_W     = 256;
  localparam int BYTE_W     = 8;
  localparam int NUM_BYTES  = 32;
  localparam int FRAME_BITS = 10;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

`ifdef HASH_TX_SYNC_BYTE_EN
  localparam int NUM_FRAMES = NUM_BYTES + 1;
  localparam int CNT_W      = 6;
`else
  localparam int NUM_FRAMES = NUM_BYTES;
  localparam int CNT_W      = 5;
`endif

  // Line bits per hash transfer, start and stop bits included.
  localparam int XFER_BITS = NUM_FRAMES * FRAME_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/hash_uart_tx_if.sv
// Valid/ready hash handoff between the SHA-256 core (master) and the UART transmitter (slave).
interface hash_uart_tx_if;
  import hash_tx_pkg::*;

  logic              hash_valid;
  logic              hash_ready;
  logic [HASH_W-1:0] hash_data;

  modport master (output hash_valid, output hash_data, input hash_ready);
  modport slave  (input hash_valid, input hash_data, output hash_ready);

endinterface

// File: rtl/hash_uart_tx_byte.sv
// 8N1 framer for one byte; data bits are read live from byte_data_i, so the caller must hold it
// stable for the frame. A byte_valid_i seen on the final stop-bit cycle starts the next frame with no gap.
module uart_tx_byte
  import hash_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_data_i,
  output logic              byte_done_o,
  output logic              txd_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic              txd_q;
  logic              bit_end;

  assign bit_end     = (baud_q == BAUD_LAST);
  assign byte_done_o = (state_q == STOP) && bit_end;
  assign txd_o       = txd_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register in this block
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          txd_q     <= 1'b1;
          if (byte_valid_i) begin
            state_q <= START;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= byte_data_i[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= byte_data_i[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (byte_valid_i) begin
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/hash_uart_tx.sv
// Sends a 256-bit hash MSB byte first over an 8N1 UART line, frames back to back.
// Build macro HASH_TX_SYNC_BYTE_EN prefixes each transfer with a SYNC_BYTE frame.
module hash_uart_tx
  import hash_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst_n,
  hash_uart_tx_if.slave  hash_s,
  output logic           uart_txd_o,
  output logic           busy_o
);

  logic              hash_ready_q, hash_ready_d;
  logic [HASH_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

  logic              accept;
  logic              last_frame;
  logic              byte_valid;
  logic              byte_done;
  logic [BYTE_W-1:0] byte_data;

  assign accept     = hash_s.hash_valid & hash_ready_q;
  assign last_frame = (byte_cnt_q == CNT_W'(NUM_FRAMES - 1));
  // High on the accept edge and at every stop-bit end except the last, chaining frames gap-free.
  assign byte_valid = accept | (~hash_ready_q & ~last_frame);

`ifdef HASH_TX_SYNC_BYTE_EN
  logic sync_sel;
  assign sync_sel  = (byte_cnt_q == '0);
  assign byte_data = sync_sel ? SYNC_BYTE : shreg_q[HASH_W-1 -: BYTE_W];
`else
  assign byte_data = shreg_q[HASH_W-1 -: BYTE_W];
`endif

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    hash_ready_d = hash_ready_q;
    shreg_d      = shreg_q;
    byte_cnt_d   = byte_cnt_q;
    if (accept) begin
      hash_ready_d = 1'b0;
      shreg_d      = hash_s.hash_data;
      byte_cnt_d   = '0;
    end else if (!hash_ready_q && byte_done) begin
      if (last_frame) begin
        hash_ready_d = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
`ifdef HASH_TX_SYNC_BYTE_EN
        if (!sync_sel) begin
          shreg_d = {shreg_q[HASH_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        end
`else
        shreg_d = {shreg_q[HASH_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
`endif
      end
    end
  end

  // NOTE: the shift register is reset too, so an aborted transfer leaves no stale hash behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_ready_q <= 1'b1;
      shreg_q      <= '0;
      byte_cnt_q   <= '0;
    end else begin
      hash_ready_q <= hash_ready_d;
      shreg_q      <= shreg_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_done_o  (byte_done),
    .txd_o        (uart_txd_o)
  );

  assign hash_s.hash_ready = hash_ready_q;
  assign busy_o            = ~hash_ready_q;

endmodule

// File: tb/tb_hash_uart_tx.sv
// Directed bench for hash_uart_tx at CLKS_PER_BIT=4: decodes uart_txd at mid-bit and checks
// framing, byte order, transfer length, busy-ignore, back-to-back and mid-transfer reset.
module tb_hash_uart_tx;

  localparam int CPB = 4;
`ifdef HASH_TX_SYNC_BYTE_EN
  localparam int TB_FRAMES = 33;
`else
  localparam int TB_FRAMES = 32;
`endif
  localparam int EXP_LEN = TB_FRAMES * 10 * CPB;

  logic clk;
  logic rst_n;
  logic uart_txd;
  logic busy;

  hash_uart_tx_if hif ();

  hash_uart_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hash_s     (hif),
    .uart_txd_o (uart_txd),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [255:0] hash;
    logic [255:0] exp_stream;
    bit           hold_ones;
  } vec_t;

  vec_t vecs [3];
  logic cap [0:EXP_LEN];

  // Caller sits on a negedge with hash_valid/hash_data already driven.
  task automatic xfer(input string tag, input logic [255:0] exp_stream, input bit hold_ones);
    int           ready_at;
    int           busy_err;
    int           frame_err;
    logic [255:0] es;
    es = exp_stream;
    check({tag, "_ready_before"}, hif.hash_ready, 1'b1);
    @(posedge clk);
    #1;
    check({tag, "_accept_low"}, uart_txd, 1'b0);
    check({tag, "_ready_drop"}, hif.hash_ready, 1'b0);
    if (hold_ones) hif.hash_data = '1;
    else           hif.hash_valid = 1'b0;
    ready_at = -1;
    busy_err = 0;
    for (int cyc = 0; cyc <= EXP_LEN; cyc++) begin
      @(negedge clk);
      cap[cyc] = uart_txd;
      if (busy !== ~hif.hash_ready) busy_err++;
      if (hif.hash_ready === 1'b1 && ready_at < 0) ready_at = cyc;
    end
    check({tag, "_ready_len"}, 256'(ready_at), 256'(EXP_LEN));
    check({tag, "_busy_inv"}, 256'(busy_err), 256'd0);
    check({tag, "_idle_gap"}, cap[EXP_LEN], 1'b1);
    frame_err = 0;
    for (int f = 0; f < TB_FRAMES; f++) begin
      int         base;
      logic [7:0] got;
      logic [7:0] expb;
      base = f * 10 * CPB;
      if (cap[base + 2] !== 1'b0) frame_err++;
      if (cap[base + 9 * CPB + 2] !== 1'b1) frame_err++;
      for (int k = 0; k < 8; k++) got[k] = cap[base + (k + 1) * CPB + 2];
`ifdef HASH_TX_SYNC_BYTE_EN
      if (f == 0) expb = 8'hA5;
      else        expb = es[255 - 8 * (f - 1) -: 8];
`else
      expb = es[255 - 8 * f -: 8];
`endif
      check($sformatf("%s_byte%0d", tag, f), 256'(got), 256'(expb));
    end
    check({tag, "_framing"}, 256'(frame_err), 256'd0);
  endtask

  initial begin
    int quiet_err;

    vecs[0] = '{256'hdeadbeefcafe0000000000000000000000000000000000000000000000000170,
                256'hdeadbeefcafe0000000000000000000000000000000000000000000000000170, 1'b1};
    vecs[1] = '{{256{1'b1}}, {256{1'b1}}, 1'b0};
    vecs[2] = '{256'h800155aa800155aa800155aa800155aa800155aa800155aa800155aa800155aa,
                256'h800155aa800155aa800155aa800155aa800155aa800155aa800155aa800155aa, 1'b0};

    rst_n          = 1'b0;
    hif.hash_valid = 1'b0;
    hif.hash_data  = '0;

    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_ready", hif.hash_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    quiet_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || hif.hash_ready !== 1'b1 || busy !== 1'b0) quiet_err++;
    end
    check("idle_quiet", 256'(quiet_err), 256'd0);

    // vecs[0] holds an all-ones hash on the bus while busy; vecs[1] expects it next, back to back.
    for (int i = 0; i < 3; i++) begin
      hif.hash_data  = vecs[i].hash;
      hif.hash_valid = 1'b1;
      xfer($sformatf("v%0d", i), vecs[i].exp_stream, vecs[i].hold_ones);
    end

    hif.hash_data  = vecs[0].hash;
    hif.hash_valid = 1'b1;
    @(posedge clk);
    #1;
    hif.hash_valid = 1'b0;
    check("mid_accept_low", uart_txd, 1'b0);
    // Negedge index 205 falls in data bit 0 of frame 5, which is a 0 in either build.
    repeat (206) @(negedge clk);
    check("mid_pre_bit", uart_txd, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd", uart_txd, 1'b1);
    check("mid_rst_ready", hif.hash_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_err = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || hif.hash_ready !== 1'b1) quiet_err++;
    end
    check("mid_no_resume", 256'(quiet_err), 256'd0);

    hif.hash_data  = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
    hif.hash_valid = 1'b1;
    xfer("post_rst", 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hash_uart_tx.md
Name: hash_uart_tx

Overview:
- Transmit end of the miner's host link: takes a 256-bit hash result from the SHA-256 core and sends it to the host over a UART line, 8N1.
- One registered output line; valid/ready handshake on the core side.
- Hash bytes go most-significant byte first; bits within each byte go LSB first.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Legal minimum is 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- hash_valid  input  1  hash_data is valid.
- hash_ready  output  1  block can accept a hash.
- hash_data  input  256  hash word; [255:248] is sent first.
- uart_txd  output  1  serial line; idles high.
- busy  output  1  transfer in progress; always equal to ~hash_ready.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - uart_txd=1, hash_ready=1, busy=0.
  - FSM goes to IDLE; all counters and the shift register clear.
- FSM states: IDLE, START, DATA, STOP.
- Accept: a hash is accepted on the rising edge where hash_valid && hash_ready.
  - hash_data is latched into a 256-bit shift register.
  - hash_ready drops at that same edge.
  - FSM moves to START; uart_txd goes low on that edge (registered).
- Bit timing:
  - Every bit, including start and stop, is held exactly CLKS_PER_BIT cycles.
  - Baud counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- START: drive 0 for one bit time, then go to DATA.
- DATA:
  - Drive shreg[248+bit_idx] for bit_idx = 0..7 (LSB first).
  - After bit 7, go to STOP.
- STOP: drive 1 for one bit time.
  - If byte_cnt < 31: shift the register left 8, byte_cnt++, go to START. There is no idle gap between frames.
  - If byte_cnt == 31: go to IDLE and raise hash_ready on the edge that ends the final stop bit.
- Transfer length: 32 frames × 10 bits × CLKS_PER_BIT cycles, counted from the accept edge to hash_ready rising. This is 1280 cycles for CLKS_PER_BIT=4.
- Counters: byte_cnt is 5 bits (0..31); bit_idx is 3 bits.
- While busy:
  - hash_valid and hash_data are ignored. Nothing is queued and nothing is overwritten.
  - The source must hold hash_valid until it sees hash_ready.
- Back-to-back: if hash_valid is high on the edge where hash_ready rises, it is accepted on the next edge. uart_txd is 1 for exactly one cycle between the two transfers.
- Reset mid-transfer: the transfer is aborted, uart_txd returns high immediately, and no partial frame resumes after reset is released.

Optional Feature:
- Macro: HASH_TX_SYNC_BYTE_EN.
- Defined:
  - Each transfer is prefixed by one frame carrying SYNC_BYTE (8'hA5), so there are 33 frames. byte_cnt is 6 bits.
  - The sync frame comes from a dedicated mux select, not from the shift register.
  - Transfer length is 330 × CLKS_PER_BIT cycles.
- Not defined: exactly 32 frames as above, with no sync byte logic synthesised.

Decomposition:
- Package hash_tx_pkg:
  - Constants HASH_W=256, BYTE_W=8, NUM_BYTES=32, FRAME_BITS=10, SYNC_BYTE=8'hA5.
  - FSM state encoding as localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
- One sub-module: uart_tx_byte.
  - Handles the start/data/stop timing for a single byte.
  - Ports: clk, rst_n, byte_valid, byte_data[7:0], byte_done, txd.
- hash_uart_tx keeps the hash shift register, the byte counter, the handshake and the sync-byte select.

Test Plan (CLKS_PER_BIT=4; the bench decodes uart_txd by sampling at mid-bit):
- Reset: hold rst_n=0 for 3 cycles, then release → uart_txd=1, hash_ready=1, busy=0 throughout, with no transitions until hash_valid.
- Basic transfer: present hash_data=256'hdeadbeefcafe0000…0170 with hash_valid for 1 cycle →
  - uart_txd is low on the accept edge; the start bit lasts exactly 4 cycles.
  - Decoded bytes are DE AD BE EF CA FE 00 … 01 70, with every stop bit = 1.
  - hash_ready returns exactly 1280 cycles after the accept edge.
- Busy ignore: during the first transfer, drive hash_valid=1 with hash_data=all-ones → it is not accepted and the decoded stream is unchanged. On hash_ready=1 the all-ones hash is accepted on the next edge, and the decoded output is 32 × 0xFF.
- Reset mid-transfer: assert rst_n=0 during the data bits of byte 5 → uart_txd=1 and hash_ready=1 asynchronously. After release, a new hash 256'h0102…20 decodes as 01..20 with no leftover bits.
- Sync option (HASH_TX_SYNC_BYTE_EN defined): send hash_data=256'hdeadbeefcafe0000…0170 → the first decoded frame is 0xA5, followed by the 32 hash bytes DE AD BE EF CA FE 00 … 01 70. hash_ready returns 1320 cycles after the accept edge.
